// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator/detector pair: FSM states and
// the nominal-period / tolerance-window calculation.
package tone_pkg;

   typedef enum logic {IDLE, MEASURE} state_t;

   localparam int CLK_HZ_DEF = 50_000_000;

   typedef struct packed {
      logic [31:0] nom;
      logic [31:0] lo;
      logic [31:0] hi;
   } window_t;

   // Integer-arithmetic period window; also used by the buzzer for its divider.
   function automatic window_t calc_window(input int clk_hz, input int tone_hz, input int tol_pct);
      window_t w;
      int nom;
      int tol;
      nom   = clk_hz / tone_hz;
      tol   = nom * tol_pct / 100;
      w.nom = 32'(nom);
      w.lo  = 32'(nom - tol);
      w.hi  = 32'(nom + tol);
      return w;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronises the asynchronous tone input and emits a one-cycle rising-edge
// pulse; TONE_DETECTOR_GLITCH_FILTER_EN adds a 4-clk stability filter.
module edge_sync
   import tone_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic sync1;
   logic sync2;
   logic sync3;
   logic level;

`ifdef TONE_DETECTOR_GLITCH_FILTER_EN
   logic [1:0] hold;

   // level follows sync2 only after it has differed for 4 consecutive samples
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         level <= 1'b0;
         hold  <= 2'd0;
      end else if (sync2 == level) begin
         hold <= 2'd0;
      end else if (hold == 2'd3) begin
         level <= sync2;
         hold  <= 2'd0;
      end else begin
         hold <= hold + 2'd1;
      end
   end
`else
   assign level = sync2;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
      end else begin
         sync1 <= din;
         sync2 <= sync1;
         sync3 <= level;
      end
   end

   assign rise = level & ~sync3;

endmodule

// File: rtl/tone_detector.sv
// Measures the period of a square-wave input and flags a target tone after
// MATCH_COUNT consecutive in-window periods. Optional macro: TONE_DETECTOR_GLITCH_FILTER_EN.
module tone_detector
   import tone_pkg::*;
#(
   parameter int CLK_HZ      = CLK_HZ_DEF,
   parameter int TONE_HZ     = 440,
   parameter int TOL_PCT     = 5,
   parameter int MATCH_COUNT = 4,
   parameter int PERIOD_W    = 24
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tone_in,
   output logic [PERIOD_W-1:0] period,
   output logic                period_valid,
   output logic                detect
);

   localparam window_t WIN    = calc_window(CLK_HZ, TONE_HZ, TOL_PCT);
   localparam longint  TMO_L  = 2 * longint'(WIN.hi);
   localparam int      MW     = $clog2(MATCH_COUNT + 1);

   localparam logic [PERIOD_W-1:0] LO  = PERIOD_W'(WIN.lo);
   localparam logic [PERIOD_W-1:0] HI  = PERIOD_W'(WIN.hi);
   localparam logic [PERIOD_W-1:0] TMO = PERIOD_W'(TMO_L);
   localparam logic [MW-1:0]       MATCH_MAX = MW'(MATCH_COUNT);

   // The counter must be able to reach the timeout without wrapping.
   if (TMO_L >= (longint'(1) << PERIOD_W)) begin : g_tmo_check
      $error("tone_detector: timeout does not fit in PERIOD_W bits");
   end

   logic rise;

   edge_sync u_edge_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (tone_in),
      .rise (rise)
   );

   state_t              state;
   state_t              state_next;
   logic [PERIOD_W-1:0] cnt;
   logic [PERIOD_W-1:0] cnt_next;
   logic [MW-1:0]       match_cnt;
   logic [MW-1:0]       match_next;
   logic [PERIOD_W-1:0] period_next;
   logic                valid_next;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         match_cnt    <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         detect       <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         match_cnt    <= match_next;
         period       <= period_next;
         period_valid <= valid_next;
         detect       <= (match_next == MATCH_MAX);
      end
   end

   // A rise in the timeout cycle is still a measurement (out of window).
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      match_next  = match_cnt;
      period_next = period;
      valid_next  = 1'b0;
      case (state)
         IDLE: begin
            cnt_next = '0;
            if (rise) begin
               cnt_next   = PERIOD_W'(1);
               state_next = MEASURE;
            end
         end
         MEASURE: begin
            if (rise) begin
               period_next = cnt;
               valid_next  = 1'b1;
               cnt_next    = PERIOD_W'(1);
               if (cnt >= LO && cnt <= HI) begin
                  match_next = (match_cnt == MATCH_MAX) ? match_cnt : match_cnt + MW'(1);
               end else begin
                  match_next = '0;
               end
            end else if (cnt == TMO) begin
               state_next = IDLE;
               match_next = '0;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + PERIOD_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_tone_detector.sv
// Scoreboard bench for tone_detector, scaled to a 100-cycle nominal period
// (CLK_HZ=1000, TONE_HZ=10: window 95..105, timeout 210).
module tb_tone_detector;

   localparam int PW = 12;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tone_in = 1'b0;
   logic [PW-1:0] period;
   logic          period_valid;
   logic          detect;

   int checks = 0;
   int failures = 0;

   typedef struct packed {
      logic [31:0] p;
      logic        d;
   } exp_t;

   exp_t sb[$];

   tone_detector #(
      .CLK_HZ     (1000),
      .TONE_HZ    (10),
      .TOL_PCT    (5),
      .MATCH_COUNT(4),
      .PERIOD_W   (PW)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .tone_in     (tone_in),
      .period      (period),
      .period_valid(period_valid),
      .detect      (detect)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Monitor: every period_valid pulse must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && period_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_period_valid", 1, 0);
         end else begin
            e = sb.pop_front();
            check("period", int'(period), int'(e.p));
            check("detect_at_pulse", int'(detect), int'(e.d));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push(input int p, input bit d);
      exp_t e;
      e.p = 32'(p);
      e.d = d;
      sb.push_back(e);
   endtask

   // Called right after a rising edge; ends with the next rising edge p cycles later.
   task automatic tone_period(input int p, input bit d);
      cycles(20);
      tone_in = 1'b0;
      cycles(p - 20);
      push(p, d);
      tone_in = 1'b1;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_period"}, int'(period), 0);
      check({tag, "_period_valid"}, int'(period_valid), 0);
      check({tag, "_detect"}, int'(detect), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      tone_in = 1'b0;
      cycles(3);
      check_idle_outputs("reset");
      rst_n = 1'b1;
      cycles(5);

      // Nominal tone: first edge arms, four periods reach detect
      tone_in = 1'b1;
      tone_period(100, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b1);

      // Off-frequency tone: first short period clears detect
      for (int i = 0; i < 5; i++) tone_period(90, 1'b0);

      // Inclusive window edges, one just outside, then recovery
      tone_period(95, 1'b0);
      tone_period(105, 1'b0);
      tone_period(95, 1'b0);
      tone_period(105, 1'b1);
      tone_period(94, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b1);

      // Timeout: long low drops detect, next edge only re-arms
      cycles(20);
      tone_in = 1'b0;
      cycles(280);
      check("timeout_detect", int'(detect), 0);
      tone_in = 1'b1;
      tone_period(100, 1'b0);

      // Reset mid-measurement discards the partial count
      cycles(20);
      tone_in = 1'b0;
      cycles(30);
      rst_n = 1'b0;
      cycles(1);
      check_idle_outputs("mid_reset");
      rst_n = 1'b1;
      cycles(30);
      tone_in = 1'b1;
      tone_period(100, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b0);
      tone_period(100, 1'b1);

      // 2-clk glitch in the middle of a nominal period
      cycles(20);
      tone_in = 1'b0;
      cycles(30);
`ifdef TONE_DETECTOR_GLITCH_FILTER_EN
      tone_in = 1'b1;
      cycles(2);
      tone_in = 1'b0;
      cycles(48);
      push(100, 1'b1);
      tone_in = 1'b1;
`else
      push(50, 1'b0);
      tone_in = 1'b1;
      cycles(2);
      tone_in = 1'b0;
      cycles(48);
      push(50, 1'b0);
      tone_in = 1'b1;
`endif

      cycles(20);
      tone_in = 1'b0;
      cycles(30);
      check("pending_expected", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tone_detector.md
# tone_detector

Receive-side counterpart to the board's square-wave tone generator. Measures the period of an incoming 1-bit square wave, such as a comparator-conditioned microphone input or the speaker line looped back, in clock cycles. Asserts `detect` once a run of consecutive periods falls within a tolerance window around a target tone. Sits between the GPIO pin and the alarm/self-test logic on the 50 MHz DE10-Lite domain.

## Interface
Parameters:
- `CLK_HZ`, 50_000_000, system clock frequency
- `TONE_HZ`, 440, target tone frequency
- `TOL_PCT`, 5, ± tolerance in percent of the nominal period
- `MATCH_COUNT`, 4, consecutive in-window periods required to assert `detect`
- `PERIOD_W`, 24, width of the period counter and output

Ports:
- `clk`  input  1  system clock; all logic on rising edge
- `rst_n`  input  1  reset, synchronous, active-low
- `tone_in`  input  1  asynchronous square-wave input
- `period`  output  PERIOD_W  last measured period in clk cycles
- `period_valid`  output  1  one-cycle pulse when `period` updates
- `detect`  output  1  high while the tone is recognised

## Operation
- Input conditioning:
  - `tone_in` passes through a 2-flop synchroniser, then a third flop.
  - `rise` = sync2 & ~sync3.
- Derived localparams (integer arithmetic):
  - NOM = CLK_HZ/TONE_HZ (113636)
  - TOL = NOM*TOL_PCT/100 (5681)
  - LO = NOM−TOL (107955)
  - HI = NOM+TOL (119317)
  - TMO = 2*HI (238634)
- State machine: IDLE, MEASURE.
  - IDLE: counter held at 0. On `rise`: counter ← 1, go to MEASURE. No measurement on this edge.
  - MEASURE, on `rise`:
    - `period` ← counter; `period_valid` ← 1; counter ← 1.
    - If LO ≤ counter ≤ HI, match_cnt ← min(match_cnt+1, MATCH_COUNT).
    - Otherwise match_cnt ← 0.
  - MEASURE, no `rise`:
    - counter increments.
    - When counter reaches TMO: go to IDLE, match_cnt ← 0, counter ← 0, no `period_valid`.
- `detect` = registered (match_cnt == MATCH_COUNT). It updates in the same cycle as the `period_valid` that changes match_cnt.
- An ideal square wave of P cycles yields `period` = P exactly.
- Window bounds are inclusive.
- Counter never wraps: TMO < 2^PERIOD_W. Elaboration fails if TMO ≥ 2^PERIOD_W.
- Reset mid-measurement discards the partial count. The next edge is treated as a first edge (IDLE behaviour).

## Timing
- Reset values: `period`=0, `period_valid`=0, `detect`=0, state=IDLE, match_cnt=0, synchroniser flops=0.
- Pin-to-`rise` latency: 3 clk (synchroniser + edge flop).
- `rise`-to-output latency: `period`/`period_valid`/`detect` registered 1 clk after the `rise` cycle.
- `period_valid` is exactly one cycle wide. Minimum spacing equals the measured period.
- Timeout: `detect` drops 1 clk after the counter hits TMO.
- Simultaneous `rise` and timeout cycle: `rise` wins. It is a measurement, and the period is out-of-window, so match_cnt clears.
- `rst_n` low has priority over all events.

## Configuration
- `TONE_DETECTOR_GLITCH_FILTER_EN` defined:
  - A stability filter sits after the synchroniser.
  - The filtered level changes only after the synchronised input holds a new value for 4 consecutive clk.
  - Pin-to-`rise` latency becomes 7 clk; measured periods are unchanged for clean input.
- Not defined: sync2/sync3 feed edge detection directly, and every synchronised pulse counts.

## Structure
- Shared package `tone_pkg`:
  - state enum (IDLE, MEASURE)
  - CLK_HZ default
  - helper function computing NOM/LO/HI from frequency and tolerance, also reused by the buzzer
- Sub-module `edge_sync`: synchroniser, optional glitch filter (macro-guarded inside), rising-edge pulse. Everything else lives in `tone_detector`.

## Test plan
- 440 Hz: 5 rising edges 113636 clk apart → 4 `period_valid` pulses each with `period`=113636; `detect`=1 coincident with the 4th pulse.
- 500 Hz: 6 edges 100000 apart → `period`=100000 each pulse, `detect` stays 0.
- Window boundaries:
  - periods 107955, 119317, 107955, 119317 → `detect`=1
  - then one period of 107954 → `detect`=0 with that pulse
  - then 4 good periods → `detect`=1 again
- Timeout:
  - after `detect`=1, hold `tone_in` low 238634 clk → `detect`=0, state IDLE
  - next edge → no `period_valid`
  - the edge after that, 113636 later → `period`=113636
- Reset mid-measurement: `rst_n` low for 1 clk at 50000 cycles into a period → all outputs 0; following edge produces no `period_valid`.
- Glitch pulse, a 2-clk high pulse mid-period:
  - with macro: ignored, `period`=113636
  - without macro: two short periods, `detect` clears
